// File: rtl/spi_cache_line_fill.sv
// Line-fill engine: packs flash bytes little-endian into 32-bit words
// and writes one cache line into the single-port data RAM.
module spi_cache_line_fill #(
    parameter  int LINE_WORDS = 8,
    parameter  int ADDR_W     = 10,
    localparam int WC_W       = $clog2(LINE_WORDS),
    localparam int LINE_W     = ADDR_W - WC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fill_req_i,
    input  logic [LINE_W-1:0] fill_line_i,
    output logic              fill_ack_o,
    input  logic              abort_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              busy_o,
    output logic              fill_done_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic [3:0]        ram_we_o
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_e;

    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic [LINE_W-1:0] line_q;
    logic [1:0]        byte_cnt_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic [31:0]       word_q;
    logic              xfer;

    assign xfer = byte_valid_i & byte_ready_o;

    always_comb begin
        state_d      = state_q;
        fill_ack_o   = 1'b0;
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        fill_done_o  = 1'b0;
        ram_en_o     = 1'b0;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        ram_we_o     = 4'h0;
        // Outputs stay quiet during the reset cycle itself
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    fill_ack_o = fill_req_i;
                    if (fill_req_i) begin
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    busy_o = 1'b1;
                    if (abort_i) begin
                        state_d = IDLE;
                    end else begin
                        byte_ready_o = 1'b1;
                        if (byte_valid_i && byte_cnt_q == 2'd3) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    busy_o = 1'b1;
                    if (abort_i) begin
                        state_d = IDLE;
                    end else begin
                        ram_en_o    = 1'b1;
                        ram_we_o    = 4'hF;
                        ram_addr_o  = {line_q, word_cnt_q};
                        ram_wdata_o = word_q;
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = DONE;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
                DONE: begin
                    busy_o      = 1'b1;
                    fill_done_o = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            line_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state_q <= state_d;
            if (fill_ack_o) begin
                line_q     <= fill_line_i;
                byte_cnt_q <= '0;
                word_cnt_q <= '0;
                word_q     <= '0;
            end
            if (xfer) begin
                word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_i;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (ram_en_o && word_cnt_q != LAST_WORD) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cache_line_fill.sv
// Randomized scoreboard bench for spi_cache_line_fill: expected RAM
// writes and done pulses are queued by stimulus and popped by a monitor.
module tb_spi_cache_line_fill;

    localparam int LW  = 8;
    localparam int AW  = 10;
    localparam int LNW = 7;
    localparam int NB  = LW * 4;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           fill_req_i = 1'b0;
    logic [LNW-1:0] fill_line_i = '0;
    logic           fill_ack_o;
    logic           abort_i = 1'b0;
    logic           byte_valid_i = 1'b0;
    logic [7:0]     byte_i = '0;
    logic           byte_ready_o;
    logic           busy_o;
    logic           fill_done_o;
    logic           ram_en_o;
    logic [AW-1:0]  ram_addr_o;
    logic [31:0]    ram_wdata_o;
    logic [3:0]     ram_we_o;

    spi_cache_line_fill #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .fill_req_i  (fill_req_i),
        .fill_line_i (fill_line_i),
        .fill_ack_o  (fill_ack_o),
        .abort_i     (abort_i),
        .byte_valid_i(byte_valid_i),
        .byte_i      (byte_i),
        .byte_ready_o(byte_ready_o),
        .busy_o      (busy_o),
        .fill_done_o (fill_done_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_we_o    (ram_we_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    int         done_q[$];
    logic [7:0] tx[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every RAM write and done pulse must match the queues
    always @(negedge clk) begin
        if (ram_en_o) begin
            if (wr_q.size() == 0) begin
                fail($sformatf("unexpected_write addr=%0d", ram_addr_o));
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 64'(ram_addr_o), 64'(e.addr));
                chk("wr_data", 64'(ram_wdata_o), 64'(e.data));
                chk("wr_we", 64'(ram_we_o), 64'hF);
                chk("ready_in_write", 64'(byte_ready_o), 64'd0);
            end
        end
        if (fill_done_o) begin
            if (done_q.size() == 0) begin
                fail("unexpected_done");
            end else begin
                int e;
                e = done_q.pop_front();
                if (e >= 0) chk("done_cycle", 64'(cyc), 64'(e));
            end
        end
    end

    task automatic to_drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic make_tx(input int kind, input int base);
        tx.delete();
        for (int i = 0; i < NB; i++) begin
            if (kind == 0) tx.push_back(8'(base + i));
            else tx.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic push_words(input int line, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            wr_t e;
            e.addr = line * LW + w;
            e.data = {tx[4*w+3], tx[4*w+2], tx[4*w+1], tx[4*w]};
            wr_q.push_back(e);
        end
    endtask

    // Raises a request; returns the ack cycle. Leaves the bench at the
    // drive point of the cycle after the ack.
    task automatic req_ack(input int line, input bit hold, output int ack_cyc);
        int waited = 0;
        fill_req_i  = 1'b1;
        fill_line_i = LNW'(line);
        @(negedge clk);
        while (!fill_ack_o && waited < 20) begin
            to_drive_point();
            waited++;
            @(negedge clk);
        end
        chk("ack_seen", 64'(fill_ack_o), 64'd1);
        chk("ack_latency", 64'(waited), 64'd0);
        ack_cyc = cyc;
        to_drive_point();
        if (!hold) fill_req_i = 1'b0;
    endtask

    // mode 0: gap-free, 1: valid toggles, 2: random valid
    task automatic send(input int n, input int mode);
        int idx = 0;
        int t = 0;
        while (idx < n && t < 2000) begin
            logic acc;
            if (mode == 0) byte_valid_i = 1'b1;
            else if (mode == 1) byte_valid_i = (t % 2 == 0);
            else byte_valid_i = 1'($urandom_range(0, 1));
            byte_i = tx[idx];
            @(negedge clk);
            acc = byte_valid_i & byte_ready_o;
            to_drive_point();
            if (acc) idx++;
            t++;
        end
        byte_valid_i = 1'b0;
        if (idx < n) fail("send_timeout");
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy_o && t < 20) begin
            to_drive_point();
            t++;
            @(negedge clk);
        end
        chk("idle_reached", 64'(busy_o), 64'd0);
        to_drive_point();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
        chk({tag, "_en"}, 64'(ram_en_o), 64'd0);
        chk({tag, "_we"}, 64'(ram_we_o), 64'd0);
        chk({tag, "_addr"}, 64'(ram_addr_o), 64'd0);
        chk({tag, "_wdata"}, 64'(ram_wdata_o), 64'd0);
        chk({tag, "_done"}, 64'(fill_done_o), 64'd0);
    endtask

    // cut < 0: full fill. Otherwise stop after `cut` bytes and then
    // abort (kind 0) or reset (kind 1) in the following cycle.
    task automatic fill(input int line, input int mode, input int cut,
                        input int kind);
        int a;
        int nw;
        if (cut < 0) nw = LW;
        else nw = (cut % 4 == 0) ? cut / 4 - 1 : cut / 4;
        push_words(line, nw);
        req_ack(line, 1'b0, a);
        if (cut < 0) begin
            done_q.push_back(mode == 0 ? a + 5 * LW + 1 : -1);
            send(NB, mode);
            wait_idle();
        end else begin
            send(cut, mode);
            if (kind == 0) begin
                abort_i = 1'b1;
                @(negedge clk);
                chk("abort_en", 64'(ram_en_o), 64'd0);
                chk("abort_ready", 64'(byte_ready_o), 64'd0);
                chk("abort_done", 64'(fill_done_o), 64'd0);
                to_drive_point();
                abort_i = 1'b0;
                @(negedge clk);
                check_quiet("post_abort");
            end else begin
                rst_i = 1'b1;
                to_drive_point();
                rst_i = 1'b0;
                @(negedge clk);
                check_quiet("post_reset");
            end
            to_drive_point();
        end
    endtask

    initial begin
        int a1;
        int a2;
        int t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        chk("reset_ack", 64'(fill_ack_o), 64'd0);
        to_drive_point();
        rst_i = 1'b0;

        make_tx(0, 8'h00);
        fill(5, 0, -1, 0);

        make_tx(0, 8'hA0);
        fill(127, 1, -1, 0);

        make_tx(1, 0);
        fill(2, 0, 10, 0);

        make_tx(1, 0);
        fill(9, 0, 16, 0);

        make_tx(1, 0);
        fill(4, 0, 26, 1);
        make_tx(1, 0);
        fill(4, 0, -1, 0);

        // Back-to-back with request held and line changed mid-fill
        make_tx(1, 0);
        push_words(33, LW);
        req_ack(33, 1'b1, a1);
        done_q.push_back(a1 + 5 * LW + 1);
        fill_line_i = LNW'(77);
        send(NB, 0);
        t = 0;
        @(negedge clk);
        while (!fill_ack_o && t < 20) begin
            to_drive_point();
            t++;
            @(negedge clk);
        end
        a2 = cyc;
        chk("b2b_ack_cycle", 64'(a2), 64'(a1 + 5 * LW + 2));
        to_drive_point();
        fill_req_i = 1'b0;
        make_tx(1, 0);
        push_words(77, LW);
        done_q.push_back(a2 + 5 * LW + 1);
        send(NB, 0);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            make_tx(1, 0);
            fill(int'($urandom_range(0, 127)), 2, -1, 0);
        end

        repeat (3) to_drive_point();
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
